// File: rtl/mfp_sevenseg_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner: glyph codes,
// the 32-entry active-low glyph table and the blank patterns.
package mfp_sevenseg_pkg;

    localparam int DIGIT_W = 6;

    // Active-low {a, b, c, d, e, f, g}; a cleared bit lights that segment.
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;
    localparam logic [7:0] SEG_OFF     = {1'b1, GLYPH_BLANK};

    typedef enum logic [4:0] {
        CODE_0,     CODE_1,     CODE_2,     CODE_3,
        CODE_4,     CODE_5,     CODE_6,     CODE_7,
        CODE_8,     CODE_9,     CODE_A,     CODE_B,
        CODE_C,     CODE_D,     CODE_E,     CODE_F,
        CODE_SEG_A, CODE_SEG_B, CODE_SEG_C, CODE_SEG_D,
        CODE_SEG_E, CODE_SEG_F, CODE_SEG_G,
        CODE_LTR_S, CODE_LTR_I, CODE_LTR_R_UP, CODE_LTR_L,
        CODE_LTR_R, CODE_LTR_N, CODE_LTR_Y,    CODE_LTR_U,
        CODE_LTR_G
    } glyph_code_e;

    // Entry order follows glyph_code_e: hex digits, single segments a..g,
    // then the letters s, i, R, l, r, n, y, u, g.
    localparam logic [0:31][6:0] GLYPH_TABLE = {
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38,
        7'h3F, 7'h5F, 7'h6F, 7'h77, 7'h7B, 7'h7D, 7'h7E,
        7'h24, 7'h6F, 7'h08, 7'h79, 7'h7A, 7'h6A, 7'h44, 7'h63,
        7'h04
    };

    function automatic logic [6:0] glyph_of(input logic [4:0] code);
        return GLYPH_TABLE[code];
    endfunction

endpackage

// File: rtl/mfp_sevenseg_glyph.sv
// Combinational code-to-segment decoder; holds no state so all scan timing
// remains in the scanner top.
module mfp_sevenseg_glyph
    import mfp_sevenseg_pkg::*;
(
    input  logic [4:0] code_i,
    output logic [6:0] glyph_o
);

    assign glyph_o = glyph_of(code_i);

endmodule

// File: rtl/mfp_sevenseg_scanner.sv
// Multiplexed seven-segment scanner with frame-aligned double-buffered loads.
// Optional blink support is compiled in with `define SEVENSEG_BLINK_EN.
module mfp_sevenseg_scanner
    import mfp_sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  logic                          load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] digit_data,
    input  logic [NUM_DIGITS-1:0]         digit_en,
    input  logic [NUM_DIGITS-1:0]         blink_mask,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [7:0]                    seg,
    output logic                          pending,
    output logic                          frame_done
);

    localparam int SW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [SW-1:0] SLOT_LAST = SW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    logic [SW-1:0]                   slot_cnt_q, slot_cnt_d;
    logic [IW-1:0]                   idx_q, idx_d;
    logic                            frame_done_q, frame_done_d;
    logic                            pending_q, pending_d;
    logic [DIGIT_W*NUM_DIGITS-1:0]   data_shd_q, data_shd_d;
    logic [DIGIT_W*NUM_DIGITS-1:0]   data_act_q, data_act_d;
    logic [NUM_DIGITS-1:0]           en_shd_q, en_shd_d;
    logic [NUM_DIGITS-1:0]           en_act_q, en_act_d;
    logic [NUM_DIGITS-1:0]           an_q, an_d;
    logic [7:0]                      seg_q, seg_d;

    logic                            slot_last;
    logic                            frame_wrap;
    logic [DIGIT_W-1:0]              cur_digit;
    logic [6:0]                      cur_glyph;
    logic [NUM_DIGITS-1:0]           blink_off;
    logic                            digit_lit;

    assign slot_last  = (slot_cnt_q == SLOT_LAST);
    assign frame_wrap = slot_last && (idx_q == IDX_LAST);
    assign cur_digit  = data_act_q[int'(idx_q)*DIGIT_W +: DIGIT_W];
    assign digit_lit  = en_act_q[idx_q] & ~blink_off[idx_q];

    mfp_sevenseg_glyph u_glyph (
        .code_i  (cur_digit[4:0]),
        .glyph_o (cur_glyph)
    );

`ifdef SEVENSEG_BLINK_EN
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [BW-1:0]         blink_cnt_q, blink_cnt_d;
    logic                  blink_phase_q, blink_phase_d;
    logic [NUM_DIGITS-1:0] blink_shd_q, blink_shd_d;
    logic [NUM_DIGITS-1:0] blink_act_q, blink_act_d;

    // The blink mask rides the same shadow/active handoff as the digit data.
    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        blink_shd_d   = blink_shd_q;
        blink_act_d   = blink_act_q;
        if (frame_wrap) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
            if (load) begin
                blink_act_d = blink_mask;
            end else if (pending_q) begin
                blink_act_d = blink_shd_q;
            end
        end else if (load) begin
            blink_shd_d = blink_mask;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            blink_shd_q   <= '0;
            blink_act_q   <= '0;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            blink_shd_q   <= blink_shd_d;
            blink_act_q   <= blink_act_d;
        end
    end

    assign blink_off = blink_phase_q ? blink_act_q : '0;
`else
    logic blink_unused;
    assign blink_unused = ^blink_mask;
    assign blink_off    = '0;
`endif

    // Scan sequencing, load handoff and the registered anode/segment drive.
    // The first cycle of every slot is blanked so segments can settle.
    always_comb begin
        slot_cnt_d   = slot_cnt_q + SW'(1);
        idx_d        = idx_q;
        frame_done_d = frame_wrap;
        pending_d    = pending_q;
        data_shd_d   = data_shd_q;
        data_act_d   = data_act_q;
        en_shd_d     = en_shd_q;
        en_act_d     = en_act_q;
        an_d         = '1;
        seg_d        = SEG_OFF;

        if (slot_last) begin
            slot_cnt_d = '0;
            idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end

        if (frame_wrap) begin
            pending_d = 1'b0;
            if (load) begin
                data_act_d = digit_data;
                en_act_d   = digit_en;
            end else if (pending_q) begin
                data_act_d = data_shd_q;
                en_act_d   = en_shd_q;
            end
        end else if (load) begin
            data_shd_d = digit_data;
            en_shd_d   = digit_en;
            pending_d  = 1'b1;
        end

        if ((slot_cnt_q != '0) && digit_lit) begin
            an_d[idx_q] = 1'b0;
            seg_d       = {~cur_digit[5], cur_glyph};
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            slot_cnt_q   <= '0;
            idx_q        <= '0;
            frame_done_q <= 1'b0;
            pending_q    <= 1'b0;
            data_shd_q   <= '0;
            data_act_q   <= '0;
            en_shd_q     <= '0;
            en_act_q     <= '0;
            an_q         <= '1;
            seg_q        <= SEG_OFF;
        end else begin
            slot_cnt_q   <= slot_cnt_d;
            idx_q        <= idx_d;
            frame_done_q <= frame_done_d;
            pending_q    <= pending_d;
            data_shd_q   <= data_shd_d;
            data_act_q   <= data_act_d;
            en_shd_q     <= en_shd_d;
            en_act_q     <= en_act_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign pending    = pending_q;
    assign frame_done = frame_done_q;

endmodule
